// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter owner and instruction-fetch sequencer for a
// 5-stage MIPS pipeline with one branch delay slot. A redirect that arrives
// while the delay-slot fetch is still outstanding is parked in tgt_q (PEND)
// and applied once that fetch completes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      bj_npc,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pcadd4,
    output logic             ifid_en,
    output logic             ifid_bubble,
    output logic             redirect_pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic             fetch_done;
    logic             acc;
    logic [31:0]      tgt_masked;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Word-align a redirect target by clearing the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Fetch handshake, redirect acceptance and next-state selection.
    always_comb begin
        imem_req    = 1'b0;
        ifid_en     = 1'b0;
        ifid_bubble = 1'b1;
        fetch_done  = 1'b0;
        acc         = 1'b0;
        tgt_masked  = word_align(bj_npc);
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        misalign_d  = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        if (!reset) begin
            imem_req    = !stall;
            ifid_en     = !stall;
            fetch_done  = imem_req & imem_ready;
            ifid_bubble = !stall & !fetch_done;
            // pc_sel is only honoured while running and not stalled; in PEND
            // the already-latched target takes precedence.
            acc         = pc_sel & !stall & (state_q == RUN);
            misalign_d  = acc & (bj_npc[1:0] != 2'b00);

            if (imem_req && !imem_ready) begin
                wait_cnt_d = sat_inc(wait_cnt_q);
            end

            unique case (state_q)
                RUN: begin
                    if (acc && fetch_done) begin
                        pc_d = tgt_masked;
                    end else if (acc) begin
                        // Delay-slot fetch not finished yet: park the target.
                        tgt_d   = tgt_masked;
                        state_d = PEND;
                    end else if (fetch_done) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                PEND: begin
                    if (fetch_done) begin
                        pc_d    = tgt_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State register; reset discards any parked redirect and restarts at RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'd0;
            misalign_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            misalign_q <= misalign_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc               = pc_q;
    assign imem_addr        = pc_q;
    assign pcadd4           = pc_q + 32'd4;
    assign redirect_pending = (state_q == PEND);
    assign misalign_err     = misalign_q;
    assign wait_cnt         = wait_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset, stall, pc_sel, imem_ready;
    logic [31:0]      bj_npc;
    logic             imem_req, ifid_en, ifid_bubble, redirect_pending, misalign_err;
    logic [31:0]      imem_addr, pc, pcadd4;
    logic [CNT_W-1:0] wait_cnt;

    int checks = 0;
    int errors = 0;

    // Model: architectural pc, a queue of not-yet-applied redirect targets
    // (at most one), misalignment flag and the stall-cycle count.
    logic [31:0]      m_pc;
    logic [31:0]      m_q[$];
    logic             m_mis;
    int               m_wait;
    bit               m_valid = 1'b0;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .bj_npc(bj_npc),
        .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
        .pcadd4(pcadd4), .ifid_en(ifid_en), .ifid_bubble(ifid_bubble),
        .redirect_pending(redirect_pending), .misalign_err(misalign_err), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Apply inputs, let them settle, compare every output with the model.
    task automatic drive(input logic r, input logic st, input logic sel,
                         input logic [31:0] bj, input logic rdy);
        logic e_req, e_bub, e_fd;
        reset = r; stall = st; pc_sel = sel; bj_npc = bj; imem_ready = rdy;
        #1;
        if (m_valid) begin
            e_req = !r && !st;
            e_fd  = e_req && rdy;
            e_bub = r ? 1'b1 : (!st && !e_fd);
            chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            chk("ifid_en", {31'd0, ifid_en}, {31'd0, e_req});
            chk("ifid_bubble", {31'd0, ifid_bubble}, {31'd0, e_bub});
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pcadd4", pcadd4, m_pc + 32'd4);
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_q.size() != 0});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
            chk("wait_cnt", {16'd0, wait_cnt}, m_wait[31:0]);
        end
    endtask

    // Advance one clock and update the model from the inputs just applied.
    task automatic tick();
        logic req, fd, acc;
        logic [31:0] tgt;
        @(posedge clk);
        if (reset) begin
            m_pc = RESET_PC; m_q.delete(); m_mis = 1'b0; m_wait = 0; m_valid = 1'b1;
        end else begin
            req   = !stall;
            fd    = req && imem_ready;
            acc   = pc_sel && !stall && (m_q.size() == 0);
            tgt   = bj_npc & 32'hFFFF_FFFC;
            m_mis = acc && (bj_npc[1:0] != 2'b00);
            if (req && !imem_ready && m_wait < 65535) m_wait++;
            if (fd) begin
                if (m_q.size() != 0) m_pc = m_q.pop_front();
                else if (acc)        m_pc = tgt;
                else                 m_pc = m_pc + 32'd4;
            end else if (acc) begin
                m_q.push_back(tgt);
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic r, input logic st, input logic sel,
                       input logic [31:0] bj, input logic rdy);
        drive(r, st, sel, bj, rdy);
        tick();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; bj_npc = 32'd0; imem_ready = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        chk("lit_reset_req", {31'd0, imem_req}, 32'd0);
        chk("lit_reset_bubble", {31'd0, ifid_bubble}, 32'd1);
        tick();

        // Sequential fetch from reset.
        drive(0, 0, 0, 0, 1);
        chk("lit_pc0", pc, 32'h3000);
        chk("lit_wait0", {16'd0, wait_cnt}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_pc1", pc, 32'h3004);
        tick();
        // Branch in ID while delay slot 0x3008 is fetched in the same cycle.
        drive(0, 0, 1, 32'h3100, 1);
        chk("lit_pc2", pc, 32'h3008);
        chk("lit_ds_bubble", {31'd0, ifid_bubble}, 32'd0);
        chk("lit_ds_en", {31'd0, ifid_en}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("lit_pc_br", pc, 32'h3100);
        tick();
        // That cycle waited; now redirect arrives while fetch is still outstanding.
        cyc(0, 0, 1, 32'h3200, 0);
        drive(0, 0, 1, 32'h5000, 0);
        chk("lit_pend1", {31'd0, redirect_pending}, 32'd1);
        chk("lit_pend_bub", {31'd0, ifid_bubble}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_wait3", {16'd0, wait_cnt}, 32'd3);
        chk("lit_pend_pc", pc, 32'h3100);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_pc_tgt", pc, 32'h3200);
        chk("lit_pend_clr", {31'd0, redirect_pending}, 32'd0);
        tick();

        // Stall ignores pc_sel and holds pc.
        cyc(0, 1, 1, 32'h4000, 1);
        drive(0, 1, 1, 32'h4000, 1);
        chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
        chk("lit_stall_pc", pc, 32'h3204);
        tick();
        cyc(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'h3103, 1);
        chk("lit_after_stall", pc, 32'h3208);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_misalign_pc", pc, 32'h3100);
        chk("lit_misalign_hi", {31'd0, misalign_err}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_misalign_lo", {31'd0, misalign_err}, 32'd0);
        tick();

        // Reset while in PEND discards the parked target.
        cyc(0, 0, 1, 32'h3200, 0);
        cyc(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("lit_rst_pc", pc, 32'h3000);
        chk("lit_rst_pend", {31'd0, redirect_pending}, 32'd0);
        chk("lit_rst_wait", {16'd0, wait_cnt}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_rst_next", pc, 32'h3004);
        tick();

        // PC wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 0, 1);
        chk("lit_wrap_add4", pcadd4, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("lit_wrap_pc", pc, 32'h0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bj;
            bj = $urandom;
            if ($urandom_range(0, 3) != 0) bj[1:0] = 2'b00;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, bj, $urandom_range(0, 1) == 1);
        end

        // Wait counter saturation.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("lit_wait_sat", {16'd0, wait_cnt}, 32'h0000_FFFF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
